// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array front end.
package systolic_pkg;

  localparam int unsigned MATRIX_SIZE = 3;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned STREAM_LEN  = 3 * MATRIX_SIZE - 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } feeder_state_e;

  // Number of enabled array cycles needed to skew in and drain an n x n product.
  function automatic int unsigned stream_len(input int unsigned n);
    return 3 * n - 1;
  endfunction

endpackage

// File: rtl/skew_lane_mux.sv
// Picks element (t - LANE) of a buffered N-entry vector, or zero outside the skew window.
module skew_lane_mux #(
  parameter int unsigned N    = 3,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = 4,
  parameter int unsigned LANE = 0
) (
  input  logic [CW-1:0]   t,
  input  logic [N*DW-1:0] vec,
  output logic [DW-1:0]   elem_c
);

  always_comb begin
    elem_c = '0;
    for (int unsigned e = 0; e < N; e++) begin
      if (t == CW'(LANE + e)) elem_c = vec[e*DW +: DW];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers one N x N operand pair slice by slice and streams it diagonally skewed into a systolic array.
module systolic_feeder #(
  parameter int unsigned MATRIX_SIZE = systolic_pkg::MATRIX_SIZE,
  parameter int unsigned DATA_WIDTH  = systolic_pkg::DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              vec_valid,
  output logic                              vec_ready,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] a_col,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] b_row,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] left_data,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0] top_data,
  output logic                              array_en,
  output logic                              busy,
  output logic                              done
);

  import systolic_pkg::*;

  localparam int unsigned N      = MATRIX_SIZE;
  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned CW     = $clog2(3 * N);
  localparam int unsigned LAST_T = stream_len(N) - 1;

  feeder_state_e state_q, state_nxt;
  logic [CW-1:0] k_q, k_nxt, t_q, t_nxt;
  logic [DW-1:0] abuf_q [N][N];
  logic [DW-1:0] abuf_nxt [N][N];
  logic [DW-1:0] bbuf_q [N][N];
  logic [DW-1:0] bbuf_nxt [N][N];
  logic [N*DW-1:0] left_mux_c, top_mux_c;
  logic accept;
  logic ready_nxt, busy_nxt, en_nxt, done_nxt;

  assign accept = vec_valid && vec_ready;

  // Buffers with the incoming beat merged, so the first stream step sees it without a bubble.
  always_comb begin
    abuf_nxt = abuf_q;
    bbuf_nxt = bbuf_q;
    if (accept) begin
      for (int unsigned kk = 0; kk < N; kk++) begin
        if (k_q == CW'(kk)) begin
          for (int unsigned i = 0; i < N; i++) begin
            abuf_nxt[i][kk] = a_col[i*DW +: DW];
            bbuf_nxt[kk][i] = b_row[i*DW +: DW];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    abuf_q <= abuf_nxt;
    bbuf_q <= bbuf_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    k_nxt     = k_q;
    t_nxt     = t_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (N == 1) begin
            state_nxt = STREAM;
            k_nxt     = '0;
            t_nxt     = '0;
          end else begin
            state_nxt = LOAD;
            k_nxt     = k_q + CW'(1);
          end
        end
      end
      LOAD: begin
        if (accept) begin
          if (k_q == CW'(N - 1)) begin
            state_nxt = STREAM;
            k_nxt     = '0;
            t_nxt     = '0;
          end else begin
            k_nxt = k_q + CW'(1);
          end
        end
      end
      STREAM: begin
        if (t_q == CW'(LAST_T)) begin
          state_nxt = DONE;
          t_nxt     = '0;
        end else begin
          t_nxt = t_q + CW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      k_nxt     = '0;
      t_nxt     = '0;
    end
    ready_nxt = (state_nxt == IDLE) || (state_nxt == LOAD);
    busy_nxt  = (state_nxt == LOAD) || (state_nxt == STREAM);
    en_nxt    = (state_nxt == STREAM);
    done_nxt  = (state_nxt == DONE);
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [N*DW-1:0] a_row, b_col;
    always_comb begin
      a_row = '0;
      b_col = '0;
      for (int unsigned e = 0; e < N; e++) begin
        a_row[e*DW +: DW] = abuf_nxt[g][e];
        b_col[e*DW +: DW] = bbuf_nxt[e][g];
      end
    end
    skew_lane_mux #(.N(N), .DW(DW), .CW(CW), .LANE(g)) u_left (
      .t(t_nxt), .vec(a_row), .elem_c(left_mux_c[g*DW +: DW])
    );
    skew_lane_mux #(.N(N), .DW(DW), .CW(CW), .LANE(g)) u_top (
      .t(t_nxt), .vec(b_col), .elem_c(top_mux_c[g*DW +: DW])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      t_q       <= '0;
      vec_ready <= 1'b1;
      busy      <= 1'b0;
      array_en  <= 1'b0;
      done      <= 1'b0;
      left_data <= '0;
      top_data  <= '0;
    end else begin
      state_q   <= state_nxt;
      k_q       <= k_nxt;
      t_q       <= t_nxt;
      vec_ready <= ready_nxt;
      busy      <= busy_nxt;
      array_en  <= en_nxt;
      done      <= done_nxt;
      left_data <= en_nxt ? left_mux_c : '0;
      top_data  <= en_nxt ? top_mux_c : '0;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder at N=3 and N=1, with a small PE-grid model for the products.
module tb_systolic_feeder;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n, flush, vec_valid, vec_ready, array_en, busy, done;
  logic [N*DW-1:0] a_col, b_row, left_data, top_data;

  logic v1_valid, ready1, en1, busy1, done1;
  logic [DW-1:0] a1, b1, left1, top1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    logic [N*DW-1:0] left;
    logic [N*DW-1:0] top;
  } step_t;
  step_t tbl[3*N-1];

  logic [N*DW-1:0] a_beat[N];
  logic [N*DW-1:0] b_beat[N];
  int c_exp[N][N];

  logic acc_clr;
  logic [DW-1:0] lr[N][N];
  logic [DW-1:0] tr[N][N];
  int acc[N][N];
  int acc1;

  always #5 clk = ~clk;

  systolic_feeder #(.MATRIX_SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .a_col(a_col), .b_row(b_row), .left_data(left_data), .top_data(top_data),
    .array_en(array_en), .busy(busy), .done(done)
  );

  systolic_feeder #(.MATRIX_SIZE(1), .DATA_WIDTH(DW)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .vec_valid(v1_valid), .vec_ready(ready1),
    .a_col(a1), .b_row(b1), .left_data(left1), .top_data(top1),
    .array_en(en1), .busy(busy1), .done(done1)
  );

  function automatic logic [DW-1:0] lin(input int i, input int j);
    return (j == 0) ? left_data[i*DW +: DW] : lr[i][(j == 0) ? 0 : j - 1];
  endfunction

  function automatic logic [DW-1:0] tin(input int i, input int j);
    return (i == 0) ? top_data[j*DW +: DW] : tr[(i == 0) ? 0 : i - 1][j];
  endfunction

  // Output-stationary PE grid: operands flow right/down, products accumulate in place.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (acc_clr) begin
          lr[i][j]  <= '0;
          tr[i][j]  <= '0;
          acc[i][j] <= 0;
        end else if (array_en) begin
          lr[i][j]  <= lin(i, j);
          tr[i][j]  <= tin(i, j);
          acc[i][j] <= acc[i][j] + int'(lin(i, j)) * int'(tin(i, j));
        end
      end
    end
  end

  always @(posedge clk) begin
    if (acc_clr) acc1 <= 0;
    else if (en1) acc1 <= acc1 + int'(left1) * int'(top1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
  endtask

  task automatic send(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    logic r;
    logic got;
    got = 1'b0;
    vec_valid = 1'b1;
    a_col = a;
    b_row = b;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      r = vec_ready;
      tick();
      if (r) begin
        got = 1'b1;
        break;
      end
    end
    chk("beat_accept", 64'(got), 64'd1);
    vec_valid = 1'b0;
  endtask

  task automatic load_all(input int gap);
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("ready_in_gap", 64'(vec_ready), 64'd1);
          tick();
        end
      end
      send(a_beat[k], b_beat[k]);
    end
  endtask

  // Starts in the first STREAM cycle; ends in the IDLE cycle after the done pulse.
  task automatic check_stream(input string nm);
    for (int t = 0; t < 3*N-1; t++) begin
      @(negedge clk);
      chk({nm, "_left"}, 64'(left_data), 64'(tbl[t].left));
      chk({nm, "_top"}, 64'(top_data), 64'(tbl[t].top));
      chk({nm, "_en"}, 64'({array_en, busy, vec_ready, done}), 64'b1100);
      tick();
    end
    @(negedge clk);
    chk({nm, "_done"}, 64'({array_en, busy, vec_ready, done}), 64'b0001);
    chk({nm, "_done_data"}, 64'({left_data, top_data}), 64'd0);
    tick();
  endtask

  task automatic check_acc(input string nm);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_acc%0d%0d", nm, i, j), 64'(acc[i][j]), 64'(c_exp[i][j]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // A = B = [[1,2,3],[4,5,6],[7,8,9]]; lanes packed {lane2,lane1,lane0}
    a_beat[0] = {8'd7, 8'd4, 8'd1};
    a_beat[1] = {8'd8, 8'd5, 8'd2};
    a_beat[2] = {8'd9, 8'd6, 8'd3};
    b_beat[0] = {8'd3, 8'd2, 8'd1};
    b_beat[1] = {8'd6, 8'd5, 8'd4};
    b_beat[2] = {8'd9, 8'd8, 8'd7};
    c_exp = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};
    tbl[0] = '{left: {8'd0, 8'd0, 8'd1}, top: {8'd0, 8'd0, 8'd1}};
    tbl[1] = '{left: {8'd0, 8'd4, 8'd2}, top: {8'd0, 8'd2, 8'd4}};
    tbl[2] = '{left: {8'd7, 8'd5, 8'd3}, top: {8'd3, 8'd5, 8'd7}};
    tbl[3] = '{left: {8'd8, 8'd6, 8'd0}, top: {8'd6, 8'd8, 8'd0}};
    tbl[4] = '{left: {8'd9, 8'd0, 8'd0}, top: {8'd9, 8'd0, 8'd0}};
    for (int t = 5; t < 3*N-1; t++) tbl[t] = '{left: '0, top: '0};

    rst_n = 1'b0; flush = 1'b0; vec_valid = 1'b0; a_col = '0; b_row = '0;
    v1_valid = 1'b0; a1 = '0; b1 = '0; acc_clr = 1'b1;
    #12;
    chk("reset_ctrl", 64'({vec_ready, busy, array_en, done}), 64'b1000);
    chk("reset_data", 64'({left_data, top_data}), 64'd0);
    chk("reset_n1", 64'({ready1, busy1, en1, done1, left1, top1}), 64'h80000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    acc_clr = 1'b0;

    // N=1: single beat goes straight to STREAM for two enabled cycles
    v1_valid = 1'b1; a1 = 8'd5; b1 = 8'd7;
    tick();
    v1_valid = 1'b0;
    @(negedge clk);
    chk("n1_t0", 64'({en1, busy1, ready1, left1, top1}), 64'({3'b110, 8'd5, 8'd7}));
    tick();
    @(negedge clk);
    chk("n1_t1", 64'({en1, busy1, left1, top1}), 64'({2'b11, 16'd0}));
    tick();
    @(negedge clk);
    chk("n1_done", 64'({en1, busy1, done1}), 64'b001);
    chk("n1_acc", 64'(acc1), 64'd35);
    tick();
    @(negedge clk);
    chk("n1_idle", 64'({done1, ready1}), 64'b01);
    tick();

    // Basic back-to-back load, with a beat held (backpressured) through the stream
    clear_acc();
    load_all(0);
    vec_valid = 1'b1; a_col = a_beat[0]; b_row = b_beat[0];
    check_stream("basic");
    check_acc("basic");
    @(negedge clk);
    chk("bp_idle_ready", 64'({vec_ready, busy}), 64'b10);
    tick();
    vec_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 64'({busy, vec_ready, array_en}), 64'b110);

    // Gapped load of the remaining two beats
    clear_acc();
    for (int k = 1; k < N; k++) begin
      for (int g = 0; g < 2; g++) begin
        @(negedge clk);
        chk("gap_ready", 64'({vec_ready, busy}), 64'b11);
        tick();
      end
      send(a_beat[k], b_beat[k]);
    end
    check_stream("gapped");
    check_acc("gapped");

    // Flush at t=3 of STREAM
    clear_acc();
    load_all(0);
    repeat (3) tick();
    @(negedge clk);
    chk("flush_pre_t3", 64'(left_data), 64'(tbl[3].left));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_ctrl", 64'({array_en, busy, done, vec_ready}), 64'b0001);
    chk("flush_data", 64'({left_data, top_data}), 64'd0);
    tick();
    @(negedge clk);
    chk("flush_no_done", 64'({done, array_en}), 64'b00);
    clear_acc();
    load_all(1);
    check_stream("post_flush");
    check_acc("post_flush");

    // Async reset in the middle of LOAD
    clear_acc();
    send(a_beat[0], b_beat[0]);
    send(a_beat[1], b_beat[1]);
    chk("load_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 64'({busy, vec_ready, array_en, done}), 64'b0100);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    load_all(0);
    check_stream("post_reset");
    check_acc("post_reset");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
